// File: rtl/sisc_pkg.sv
// Shared pipeline package: bus widths, arbiter state/owner encodings
// and the fetch-starvation burst counter update.
package sisc_pkg;

  localparam int ADDRSIZE = 12;
  localparam int WIDTH    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_e;

  function automatic logic [3:0] burst_next(
    input logic [3:0] cnt,
    input logic [3:0] max,
    input logic       if_req,
    input logic       d_grant,
    input logic       if_grant
  );
    if (!if_req || if_grant) return 4'd0;
    if (d_grant && cnt != max) return cnt + 4'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request channels and the single memory port they share.
// slave = arbiter view, master = pipeline/memory view.
interface mem_port_arbiter_if
  import sisc_pkg::*;
#(
  parameter int ADDRSIZE = sisc_pkg::ADDRSIZE,
  parameter int WIDTH    = sisc_pkg::WIDTH
);

  logic                if_req;
  logic [ADDRSIZE-1:0] if_addr;
  logic                if_flush;
  logic                if_gnt;
  logic                if_valid;
  logic [WIDTH-1:0]    if_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDRSIZE-1:0] d_addr;
  logic [WIDTH-1:0]    d_wdata;
  logic                d_gnt;
  logic                d_valid;
  logic [WIDTH-1:0]    d_rdata;

  logic                mem_en;
  logic                mem_we;
  logic [ADDRSIZE-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [WIDTH-1:0]    mem_rdata;

  logic                busy;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_gnt, if_valid, if_rdata,
    output d_gnt, d_valid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr, if_flush,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_gnt, if_valid, if_rdata,
    input  d_gnt, d_valid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Fetch/data priority pick: data first unless fetch has waited
// through MAX_DBURST data grants; a flushing fetch never wins.
module mem_arb_pick
  import sisc_pkg::*;
#(
  parameter int MAX_DBURST = 4
) (
  input  logic       if_req,
  input  logic       d_req,
  input  logic       if_flush,
  input  logic [3:0] burst_cnt,
  output logic       pick_valid,
  output arb_owner_e pick_owner
);

  localparam logic [3:0] MAXB = 4'(MAX_DBURST);

  logic if_ok;
  logic if_prio;
  logic pick_d;
  logic pick_i;

  assign if_ok   = if_req && !if_flush;
  assign if_prio = if_ok && (burst_cnt == MAXB);
  assign pick_d  = d_req && !if_prio;
  assign pick_i  = if_ok && !pick_d;

  always_comb begin
    pick_valid = 1'b0;
    pick_owner = OWN_IF;
    unique case (1'b1)
      pick_d: begin
        pick_valid = 1'b1;
        pick_owner = OWN_D;
      end
      pick_i: begin
        pick_valid = 1'b1;
        pick_owner = OWN_IF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and execute LD/STR:
// request/grant/valid handshake, wait states, burst guard, flush drop.
module mem_port_arbiter
  import sisc_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int MAX_DBURST  = 4
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [3:0] WS_LAST =
    4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
  localparam logic [3:0] MAXB = 4'(MAX_DBURST);

  arb_state_e state, state_n;
  arb_owner_e owner, owner_n;
  arb_owner_e pick_owner;
  logic [3:0] wcnt, wcnt_n;
  logic [3:0] burst_cnt;
  logic       drop, drop_n;
  logic       accept;
  logic       arb_en;
  logic       pick_valid;

  // Requests only matter at arbitration edges; the owner's held
  // request is invisible while its access is in flight.
  assign arb_en = (state == IDLE) || (state == RESP);

  mem_arb_pick #(
    .MAX_DBURST (MAX_DBURST)
  ) u_pick (
    .if_req     (bus.if_req && arb_en),
    .d_req      (bus.d_req && arb_en),
    .if_flush   (bus.if_flush),
    .burst_cnt  (burst_cnt),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  always_comb begin
    state_n = state;
    owner_n = owner;
    wcnt_n  = wcnt;
    drop_n  = drop;
    accept  = 1'b0;
    if (owner == OWN_IF && bus.if_flush && state != IDLE)
      drop_n = 1'b1;
    unique case (state)
      IDLE:
        if (pick_valid) accept = 1'b1;
      ACCESS:
        if (WAIT_STATES == 0) begin
          state_n = RESP;
        end else begin
          state_n = WAIT;
          wcnt_n  = WS_LAST;
        end
      WAIT:
        if (wcnt == 4'd0) state_n = RESP;
        else wcnt_n = wcnt - 4'd1;
      RESP:
        if (pick_valid) accept = 1'b1;
        else state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
    if (accept) begin
      state_n = ACCESS;
      owner_n = pick_owner;
      drop_n  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= OWN_IF;
      wcnt          <= 4'd0;
      drop          <= 1'b0;
      burst_cnt     <= 4'd0;
      bus.if_gnt    <= 1'b0;
      bus.d_gnt     <= 1'b0;
      bus.if_valid  <= 1'b0;
      bus.d_valid   <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      state        <= state_n;
      owner        <= owner_n;
      wcnt         <= wcnt_n;
      drop         <= drop_n;
      burst_cnt    <= burst_next(burst_cnt, MAXB, bus.if_req,
                                 accept && pick_owner == OWN_D,
                                 accept && pick_owner == OWN_IF);
      bus.if_gnt   <= accept && pick_owner == OWN_IF;
      bus.d_gnt    <= accept && pick_owner == OWN_D;
      bus.mem_en   <= accept;
      bus.mem_we   <= accept && pick_owner == OWN_D && bus.d_we;
      bus.if_valid <= state_n == RESP && owner_n == OWN_IF && !drop_n;
      bus.d_valid  <= state_n == RESP && owner_n == OWN_D;
      bus.busy     <= state_n != IDLE;
      if (accept) begin
        bus.mem_addr <= (pick_owner == OWN_D) ? bus.d_addr : bus.if_addr;
        if (pick_owner == OWN_D) bus.mem_wdata <= bus.d_wdata;
      end
    end
  end

  assign bus.if_rdata = bus.mem_rdata;
  assign bus.d_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with no wait states, one with three,
// each backed by a synchronous-read memory model.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  mem_port_arbiter_if b0 ();
  mem_port_arbiter_if b3 ();

  mem_port_arbiter #(.WAIT_STATES(0), .MAX_DBURST(4)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (b0)
  );

  mem_port_arbiter #(.WAIT_STATES(3), .MAX_DBURST(4)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (b3)
  );

  logic [31:0] mem0 [4096];
  logic [31:0] mem3 [4096];

  // Word i holds C000_0000 | i, except word 5 of the first memory.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) begin
        mem0[i] <= 32'hC000_0000 | 32'(i);
        mem3[i] <= 32'hC000_0000 | 32'(i);
      end
      mem0[5] <= 32'h4000_1002;
    end else begin
      if (b0.mem_en) begin
        if (b0.mem_we) mem0[b0.mem_addr] <= b0.mem_wdata;
        b0.mem_rdata <= mem0[b0.mem_addr];
      end
      if (b3.mem_en) begin
        if (b3.mem_we) mem3[b3.mem_addr] <= b3.mem_wdata;
        b3.mem_rdata <= mem3[b3.mem_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait3_gnt(input bit data, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (data ? b3.d_gnt : b3.if_gnt) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait3_valid(input bit data, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (data ? b3.d_valid : b3.if_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  int g [8];
  int n;
  int cnt;
  bit drop_if;
  bit seen;
  int exp_g [7];

  initial begin
    b0.if_req = 0; b0.if_addr = '0; b0.if_flush = 0;
    b0.d_req = 0; b0.d_we = 0; b0.d_addr = '0; b0.d_wdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.if_flush = 0;
    b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
    #1 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    chk("rst_busy", b0.busy, 0);
    chk("rst_mem_en", b0.mem_en, 0);
    chk("rst_gnt", {b0.if_gnt, b0.d_gnt}, 0);
    chk("rst_valid", {b0.if_valid, b0.d_valid}, 0);

    // fetch only, no wait states
    b0.if_req = 1; b0.if_addr = 12'h005;
    tick();
    chk("f_gnt", b0.if_gnt, 1);
    chk("f_mem_en", b0.mem_en, 1);
    chk("f_mem_addr", b0.mem_addr, 32'h5);
    chk("f_valid_early", b0.if_valid, 0);
    tick();
    b0.if_req = 0;
    chk("f_valid", b0.if_valid, 1);
    chk("f_rdata", b0.if_rdata, 32'h4000_1002);
    chk("f_gnt_pulse", b0.if_gnt, 0);
    tick();
    chk("f_valid_pulse", b0.if_valid, 0);
    chk("f_idle", b0.busy, 0);

    // flush at an arbitration edge blocks fetch acceptance
    b0.if_req = 1; b0.if_addr = 12'h009; b0.if_flush = 1;
    tick();
    chk("fl_block_gnt", b0.if_gnt, 0);
    chk("fl_block_busy", b0.busy, 0);
    b0.if_flush = 0;
    tick();
    chk("fl_after_gnt", b0.if_gnt, 1);
    tick();
    b0.if_req = 0;
    chk("fl_after_rdata", b0.if_rdata, 32'hC000_0009);
    tick();

    // simultaneous fetch and load: data first, fetch chained
    b0.if_req = 1; b0.if_addr = 12'h006;
    b0.d_req = 1; b0.d_we = 0; b0.d_addr = 12'h010;
    tick();
    chk("s_d_gnt", b0.d_gnt, 1);
    chk("s_if_gnt_lose", b0.if_gnt, 0);
    chk("s_mem_addr", b0.mem_addr, 32'h10);
    tick();
    b0.d_req = 0;
    chk("s_d_valid", b0.d_valid, 1);
    chk("s_d_rdata", b0.d_rdata, 32'hC000_0010);
    chk("s_if_gnt_wait", b0.if_gnt, 0);
    tick();
    chk("s_if_gnt", b0.if_gnt, 1);
    chk("s_no_idle", b0.busy, 1);
    chk("s_if_addr", b0.mem_addr, 32'h6);
    tick();
    b0.if_req = 0;
    chk("s_if_valid", b0.if_valid, 1);
    chk("s_if_rdata", b0.if_rdata, 32'hC000_0006);
    tick();
    chk("s_idle", b0.busy, 0);

    // continuous data traffic vs a waiting fetch
    b0.if_req = 1; b0.if_addr = 12'h007;
    b0.d_req = 1; b0.d_we = 0; b0.d_addr = 12'h010;
    n = 0; drop_if = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (drop_if) b0.if_req = 0;
      drop_if = 0;
      if (b0.d_gnt && n < 8) begin g[n] = 1; n++; end
      if (b0.if_gnt && n < 8) begin g[n] = 2; n++; drop_if = 1; end
    end
    b0.d_req = 0;
    exp_g = '{1, 1, 1, 1, 2, 1, 1};
    chk("b_count", n, 8);
    for (int i = 0; i < 7; i++)
      chk($sformatf("b_grant%0d", i), g[i], exp_g[i]);
    cnt = 0;
    while (b0.busy && cnt < 10) begin tick(); cnt++; end
    chk("b_idle", b0.busy, 0);

    // store with three wait states
    b3.d_req = 1; b3.d_we = 1; b3.d_addr = 12'h020;
    b3.d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("st_gnt", b3.d_gnt, 1);
    chk("st_we", b3.mem_we, 1);
    chk("st_addr", b3.mem_addr, 32'h20);
    chk("st_wdata", b3.mem_wdata, 32'hDEAD_BEEF);
    tick();
    b3.d_req = 0;
    chk("st_we_pulse", b3.mem_we, 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (b3.d_valid) cnt++;
      tick();
    end
    chk("st_valid_early", cnt, 0);
    chk("st_valid", b3.d_valid, 1);
    chk("st_busy", b3.busy, 1);
    tick();
    chk("st_idle", b3.busy, 0);

    b3.d_req = 1; b3.d_we = 0;
    wait3_gnt(1, seen);
    chk("ld_gnt", seen, 1);
    tick();
    b3.d_req = 0;
    wait3_valid(1, seen);
    chk("ld_valid", seen, 1);
    chk("ld_rdata", b3.d_rdata, 32'hDEAD_BEEF);
    tick();

    // flush during the wait of a fetch
    b3.if_req = 1; b3.if_addr = 12'h030;
    tick();
    chk("fw_gnt", b3.if_gnt, 1);
    tick();
    b3.if_req = 0; b3.if_flush = 1;
    tick();
    b3.if_flush = 0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (b3.if_valid) cnt++;
      tick();
    end
    chk("fw_no_valid", cnt, 0);
    chk("fw_idle", b3.busy, 0);
    b3.if_req = 1; b3.if_addr = 12'h040;
    wait3_gnt(0, seen);
    chk("fw_new_gnt", seen, 1);
    tick();
    b3.if_req = 0;
    wait3_valid(0, seen);
    chk("fw_new_valid", seen, 1);
    chk("fw_new_rdata", b3.if_rdata, 32'hC000_0040);
    tick();

    // reset in the middle of a wait
    b3.if_req = 1; b3.if_addr = 12'h050;
    tick();
    chk("rw_gnt", b3.if_gnt, 1);
    tick();
    b3.if_req = 0;
    #2 reset = 1'b1;
    #1;
    chk("rw_busy", b3.busy, 0);
    chk("rw_mem_en", b3.mem_en, 0);
    chk("rw_valid", {b3.if_valid, b3.d_valid}, 0);
    tick(); tick();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (b3.if_valid || b3.d_valid || b3.busy) cnt++;
      tick();
    end
    chk("rw_quiet", cnt, 0);
    b3.if_req = 1; b3.if_addr = 12'h060;
    wait3_gnt(0, seen);
    chk("rw_new_gnt", seen, 1);
    chk("rw_new_addr", b3.mem_addr, 32'h60);
    tick();
    b3.if_req = 0;
    wait3_valid(0, seen);
    chk("rw_new_valid", seen, 1);
    chk("rw_new_rdata", b3.if_rdata, 32'hC000_0060);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
